iq_avg_bram_capture_ctrl: RTL

IQ_AVG_BRAM_CAPTURE_CTRL -- requirements
Module: iq_avg_bram_capture_ctrl

---
 rtl/iq_avg_bram_capture_ctrl.sv | 110 +++++++++++
 1 files changed

// File: rtl/iq_avg_bram_capture_ctrl.sv
// Arm/trigger capture controller: streams averaged IQ words into BRAM port A
// from address 0 up to a latched last address, with registered port outputs.
module iq_avg_bram_capture_ctrl #(
  parameter int ADDR_W = 10,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              arm,
  input  logic              abort,
  input  logic              trig,
  input  logic              din_valid,
  input  logic [DATA_W-1:0] din,
  input  logic [ADDR_W-1:0] last_addr,
  output logic              bram_we,
  output logic              bram_en_a,
  output logic [ADDR_W-1:0] bram_addr,
  output logic [DATA_W-1:0] bram_wr_data,
  output logic              busy,
  output logic              done,
  output logic [ADDR_W:0]   wr_count
);

  typedef enum logic [1:0] {S_IDLE, S_ARMED, S_CAPTURE, S_DONE} state_t;

  state_t              state_q, state_d;
  logic [ADDR_W-1:0]   ptr_q, ptr_d;
  logic [ADDR_W-1:0]   last_q, last_d;
  logic [ADDR_W:0]     cnt_q, cnt_d;
  logic                we_q, we_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [DATA_W-1:0]   data_q, data_d;
  logic                busy_q, busy_d;
  logic                done_q, done_d;
  logic                accept;

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    last_d  = last_q;
    cnt_d   = cnt_q;
    we_d    = 1'b0;
    addr_d  = addr_q;
    data_d  = data_q;
    accept  = 1'b0;
    if (abort) begin
      // abort wins over everything; the count of the aborted capture is kept
      state_d = S_IDLE;
    end else begin
      case (state_q)
        S_IDLE, S_DONE: if (arm) begin
          state_d = S_ARMED;
          ptr_d   = '0;
          cnt_d   = '0;
          last_d  = last_addr;
        end
        S_ARMED: if (trig) begin
          state_d = S_CAPTURE;
          accept  = din_valid;
        end
        S_CAPTURE: accept = din_valid;
        default: ;
      endcase
    end
    if (accept) begin
      we_d   = 1'b1;
      addr_d = ptr_q;
      data_d = din;
      ptr_d  = ptr_q + 1'b1;
      cnt_d  = cnt_q + 1'b1;
      // stopping on the last address keeps the pointer from ever wrapping
      if (ptr_q == last_q) state_d = S_DONE;
    end
    busy_d = (state_d == S_ARMED) || (state_d == S_CAPTURE);
    done_d = (state_d == S_DONE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      ptr_q   <= '0;
      last_q  <= '0;
      cnt_q   <= '0;
      we_q    <= 1'b0;
      addr_q  <= '0;
      data_q  <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      last_q  <= last_d;
      cnt_q   <= cnt_d;
      we_q    <= we_d;
      addr_q  <= addr_d;
      data_q  <= data_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign bram_we      = we_q;
  assign bram_en_a    = we_q;
  assign bram_addr    = addr_q;
  assign bram_wr_data = data_q;
  assign busy         = busy_q;
  assign done         = done_q;
  assign wr_count     = cnt_q;

endmodule
